// File: rtl/stepper_move_if.sv
// Command and status bundle between a motion host and stepper_move_ctrl.
// The host drives the master side and the controller uses the slave side.
interface stepper_move_if #(
  parameter int CNT_W = 16,
  parameter int PER_W = 16
);
  logic             start;
  logic             abort;
  logic             dir_in;
  logic             full_step_in;
  logic [CNT_W-1:0] target_steps;
  logic [PER_W-1:0] start_period;
  logic [PER_W-1:0] cruise_period;
  logic             step_pulse;
  logic             dir;
  logic             step;
  logic             turn_on;
  logic             busy;
  logic             done;
  logic             aborted;
  logic [CNT_W-1:0] steps_done;

  modport master (
    output start, abort, dir_in, full_step_in, target_steps, start_period, cruise_period,
    input  step_pulse, dir, step, turn_on, busy, done, aborted, steps_done
  );

  modport slave (
    input  start, abort, dir_in, full_step_in, target_steps, start_period, cruise_period,
    output step_pulse, dir, step, turn_on, busy, done, aborted, steps_done
  );
endinterface

// File: rtl/stepper_move_ctrl.sv
// Stepper move controller: runs one N-step move with a trapezoidal step-period
// profile and drives per-step strobes plus dir/step/turn_on to the phase sequencer.
module stepper_move_ctrl #(
  parameter int CNT_W     = 16,
  parameter int PER_W     = 16,
  parameter int ACCEL_DEC = 2,
  parameter int HOLD_CLKS = 1000
) (
  input logic           clk,
  input logic           rst,
  stepper_move_if.slave bus
);

  localparam int HOLD_W = (HOLD_CLKS > 0) ? $clog2(HOLD_CLKS + 1) : 1;
  localparam logic [PER_W:0]    DEC_W     = (PER_W + 1)'(ACCEL_DEC);
  localparam logic [PER_W-1:0]  DEC_P     = PER_W'(ACCEL_DEC);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CLKS);

  typedef enum logic [2:0] {IDLE, ACCEL, CRUISE, DECEL, DONE} state_t;

  state_t            state, state_n;
  logic [PER_W-1:0]  timer, timer_n;
  logic [PER_W-1:0]  cur_per, cur_per_n;
  logic [PER_W-1:0]  start_per, start_per_n;
  logic [PER_W-1:0]  cruise_per, cruise_per_n;
  logic [CNT_W-1:0]  remaining, remaining_n;
  logic [CNT_W-1:0]  accel_cnt, accel_cnt_n;
  logic [CNT_W-1:0]  steps_done, steps_done_n;
  logic [CNT_W-1:0]  rem_dec, clamp;
  logic [HOLD_W-1:0] hold_cnt, hold_cnt_n;
  logic              step_pulse, step_pulse_n;
  logic              dir, dir_n;
  logic              step, step_n;
  logic              turn_on, turn_on_n;
  logic              busy, busy_n;
  logic              done, done_n;
  logic              aborted, aborted_n;
  logic              abort_flag, abort_flag_n;
  logic [PER_W-1:0]  sp_in, cp_in, per_up, per_dn;
  logic [PER_W:0]    per_sum;

  // A zero period would stall the timer, so it is promoted to one clock.
  assign sp_in = (bus.start_period == '0) ? PER_W'(1) : bus.start_period;
  assign cp_in = (bus.cruise_period == '0) ? PER_W'(1) : bus.cruise_period;

  // Period ramps saturate at the latched limits; widened compares avoid wrap.
  assign per_sum = {1'b0, cur_per} + DEC_W;
  assign per_up  = (per_sum >= {1'b0, start_per}) ? start_per : per_sum[PER_W-1:0];
  assign per_dn  = ({1'b0, cur_per} >= ({1'b0, cruise_per} + DEC_W)) ? (cur_per - DEC_P)
                                                                      : cruise_per;

  assign rem_dec = remaining - 1'b1;

  always_comb begin
    state_n      = state;
    timer_n      = timer;
    cur_per_n    = cur_per;
    start_per_n  = start_per;
    cruise_per_n = cruise_per;
    remaining_n  = remaining;
    accel_cnt_n  = accel_cnt;
    steps_done_n = steps_done;
    hold_cnt_n   = hold_cnt;
    step_pulse_n = 1'b0;
    dir_n        = dir;
    step_n       = step;
    turn_on_n    = turn_on;
    busy_n       = busy;
    done_n       = 1'b0;
    aborted_n    = aborted;
    abort_flag_n = abort_flag;
    clamp        = '0;

    case (state)
      IDLE: begin
        if (hold_cnt != '0) begin
          hold_cnt_n = hold_cnt - 1'b1;
          if (hold_cnt == HOLD_W'(1)) turn_on_n = 1'b0;
        end
        if (bus.start) begin
          dir_n        = bus.dir_in;
          step_n       = bus.full_step_in;
          start_per_n  = sp_in;
          cruise_per_n = (cp_in >= sp_in) ? sp_in : cp_in;
          cur_per_n    = sp_in;
          timer_n      = sp_in;
          remaining_n  = bus.target_steps;
          accel_cnt_n  = '0;
          steps_done_n = '0;
          busy_n       = 1'b1;
          turn_on_n    = 1'b1;
          hold_cnt_n   = '0;
          aborted_n    = 1'b0;
          abort_flag_n = 1'b0;
          if (bus.target_steps == '0) state_n = DONE;
          else if (cp_in >= sp_in)    state_n = CRUISE;
          else                        state_n = ACCEL;
        end
      end

      ACCEL, CRUISE, DECEL: begin
        if (timer == PER_W'(1)) begin
          step_pulse_n = 1'b1;
          steps_done_n = steps_done + 1'b1;
          remaining_n  = rem_dec;
          if (rem_dec == '0) begin
            state_n = DONE;
          end else if (state != DECEL && rem_dec <= accel_cnt) begin
            state_n   = DECEL;
            cur_per_n = per_up;
          end else if (state == ACCEL) begin
            accel_cnt_n = accel_cnt + 1'b1;
            cur_per_n   = per_dn;
            if (per_dn == cruise_per) state_n = CRUISE;
          end else if (state == DECEL) begin
            cur_per_n = per_up;
          end
          timer_n = cur_per_n;
        end else begin
          timer_n = timer - 1'b1;
        end

        // Abort keeps just enough steps (the in-progress one included) to ramp down.
        if (bus.abort && state != DECEL && state_n != DONE) begin
          clamp        = (accel_cnt_n == '0) ? CNT_W'(1) : accel_cnt_n;
          abort_flag_n = 1'b1;
          state_n      = DECEL;
          if (remaining_n > clamp) remaining_n = clamp;
        end
      end

      DONE: begin
        done_n     = 1'b1;
        busy_n     = 1'b0;
        aborted_n  = abort_flag;
        hold_cnt_n = HOLD_LOAD;
        turn_on_n  = (HOLD_CLKS != 0);
        state_n    = IDLE;
      end

      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      timer      <= '0;
      cur_per    <= '0;
      start_per  <= '0;
      cruise_per <= '0;
      remaining  <= '0;
      accel_cnt  <= '0;
      steps_done <= '0;
      hold_cnt   <= '0;
      step_pulse <= 1'b0;
      dir        <= 1'b0;
      step       <= 1'b0;
      turn_on    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      aborted    <= 1'b0;
      abort_flag <= 1'b0;
    end else begin
      state      <= state_n;
      timer      <= timer_n;
      cur_per    <= cur_per_n;
      start_per  <= start_per_n;
      cruise_per <= cruise_per_n;
      remaining  <= remaining_n;
      accel_cnt  <= accel_cnt_n;
      steps_done <= steps_done_n;
      hold_cnt   <= hold_cnt_n;
      step_pulse <= step_pulse_n;
      dir        <= dir_n;
      step       <= step_n;
      turn_on    <= turn_on_n;
      busy       <= busy_n;
      done       <= done_n;
      aborted    <= aborted_n;
      abort_flag <= abort_flag_n;
    end
  end

  assign bus.step_pulse = step_pulse;
  assign bus.dir        = dir;
  assign bus.step       = step;
  assign bus.turn_on    = turn_on;
  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.aborted    = aborted;
  assign bus.steps_done = steps_done;

endmodule
